alu_shift_sequencer: RTL

//  Multi-cycle command sequencer in front of the 32-bit ALU.
//  - Accepts one command (op, A, B, shift amount) per valid/ready handshake.
//  - Drives the ALU ports.
//  - Builds N-bit shifts/rotates by re-issuing the ALU's 1-bit shift/rotate op N times,

---
 rtl/alu_shift_sequencer_if.sv | 35 +++
 rtl/alu_shift_sequencer.sv | 114 +++++++++++
 2 files changed

// File: rtl/alu_shift_sequencer_if.sv
// Command, ALU and result channels of alu_shift_sequencer bundled into one interface.
// The slave modport is the sequencer's view; master is the environment (command source, ALU, consumer).
interface alu_shift_sequencer_if #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [3:0]         in_op;
    logic [DATA_W-1:0]  in_a;
    logic [DATA_W-1:0]  in_b;
    logic [SHAMT_W-1:0] in_shamt;

    logic [DATA_W-1:0]  alu_a;
    logic [DATA_W-1:0]  alu_b;
    logic [3:0]         alu_op;
    logic [DATA_W-1:0]  alu_out;
    logic               alu_zero;

    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_result;
    logic               out_zero;
    logic               busy;

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_shamt, alu_out, alu_zero, out_ready,
        output in_ready, alu_a, alu_b, alu_op, out_valid, out_result, out_zero, busy
    );

    modport master (
        output in_valid, in_op, in_a, in_b, in_shamt, alu_out, alu_zero, out_ready,
        input  in_ready, alu_a, alu_b, alu_op, out_valid, out_result, out_zero, busy
    );
endinterface

// File: rtl/alu_shift_sequencer.sv
// Multi-cycle sequencer in front of a 1-bit-shift ALU: N-bit shifts are built by re-issuing the op N times.
// Optional macro ALU_SEQ_EARLY_EXIT_EN: logical shifts stop as soon as the accumulator reaches zero.
module alu_shift_sequencer #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_shift_sequencer_if.slave  seq_io
);
    localparam logic [3:0] OP_SRA = 4'b1000;
    localparam logic [3:0] OP_SLL = 4'b1001;
    localparam logic [3:0] OP_SRL = 4'b1010;
    localparam logic [3:0] OP_ROL = 4'b1100;
    localparam logic [3:0] OP_ROR = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [3:0]         op_q;
    logic [DATA_W-1:0]  b_q;
    logic [DATA_W-1:0]  acc_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic [SHAMT_W-1:0] cnt_d;
    logic [DATA_W-1:0]  result_q;
    logic               zero_q;
    logic               out_valid_q;
    logic               busy_q;
    logic               is_shift;
    logic               is_logical;

    assign is_shift   = (op_q == OP_SRA) || (op_q == OP_SLL) || (op_q == OP_SRL) ||
                        (op_q == OP_ROL) || (op_q == OP_ROR);
    assign is_logical = (op_q == OP_SLL) || (op_q == OP_SRL);
    assign cnt_d      = cnt_q - SHAMT_W'(1);

    // The operand registers feed the ALU directly, so they hold their last values outside EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (seq_io.in_valid) begin
                        op_q    <= seq_io.in_op;
                        b_q     <= seq_io.in_b;
                        acc_q   <= seq_io.in_a;
                        cnt_q   <= seq_io.in_shamt;
                        busy_q  <= 1'b1;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (!is_shift || cnt_q == SHAMT_W'(1)) begin
                        result_q    <= seq_io.alu_out;
                        zero_q      <= seq_io.alu_zero;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (cnt_q == '0) begin
                        result_q    <= acc_q;
                        zero_q      <= (acc_q == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
`ifdef ALU_SEQ_EARLY_EXIT_EN
                    end else if (is_logical && seq_io.alu_out == '0) begin
                        // Once a logical shift hits zero further iterations cannot change it.
                        result_q    <= '0;
                        zero_q      <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
`endif
                    end else begin
                        acc_q <= seq_io.alu_out;
                        cnt_q <= cnt_d;
                    end
                end
                DONE: begin
                    if (seq_io.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifndef ALU_SEQ_EARLY_EXIT_EN
    logic unused_logical;
    assign unused_logical = is_logical;
`endif

    assign seq_io.in_ready   = (state_q == IDLE);
    assign seq_io.alu_a      = acc_q;
    assign seq_io.alu_b      = b_q;
    assign seq_io.alu_op     = op_q;
    assign seq_io.out_valid  = out_valid_q;
    assign seq_io.out_result = result_q;
    assign seq_io.out_zero   = zero_q;
    assign seq_io.busy       = busy_q;
endmodule
